// File: rtl/mem_bus_ctrl.sv
// Memory access sequencer: turns one-cycle control requests into a valid/ready bus
// transaction with RV32 lane steering, load extension, misalignment and timeout faults.
module mem_bus_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic              is_data,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              stall,
    output logic [1:0]        fault,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t            state_q, state_d;
    size_t             size_q, size_d, req_size;
    logic              we_q, we_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        fault_q, fault_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]        bus_wstrb_q, bus_wstrb_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              misaligned;
    logic [31:0]       rd_shift, rd_ext;

    // Fetches are always word; funct3[1]=1 (LW and undefined 011/11x) decodes as word.
    always_comb begin
        if (!is_data || funct3[1]) req_size = SZ_WORD;
        else if (funct3[0])        req_size = SZ_HALF;
        else                       req_size = SZ_BYTE;
        misaligned = ((req_size == SZ_HALF) && addr[0]) ||
                     ((req_size == SZ_WORD) && (addr[1:0] != 2'b00));
    end

    always_comb begin
        rd_shift = bus_rdata >> {off_q, 3'b000};
        case (size_q)
            SZ_BYTE: rd_ext = {{24{~uns_q & rd_shift[7]}}, rd_shift[7:0]};
            SZ_HALF: rd_ext = {{16{~uns_q & rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        we_d        = we_q;
        uns_d       = uns_q;
        off_d       = off_q;
        rdata_d     = rdata_q;
        fault_d     = fault_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wstrb_d = bus_wstrb_q;
        bus_wdata_d = bus_wdata_q;
        cnt_d       = cnt_q;
        stall       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d   = we;
                    size_d = req_size;
                    uns_d  = funct3[2];
                    off_d  = addr[1:0];
                    if (misaligned) begin
                        fault_d = 2'b01;
                        state_d = DONE;
                    end else begin
                        fault_d    = 2'b00;
                        stall      = 1'b1;
                        cnt_d      = '0;
                        bus_we_d   = we;
                        bus_addr_d = {addr[ADDR_W-1:2], 2'b00};
                        case (req_size)
                            SZ_BYTE: begin
                                bus_wstrb_d = 4'b0001 << addr[1:0];
                                bus_wdata_d = {4{wdata[7:0]}};
                            end
                            SZ_HALF: begin
                                bus_wstrb_d = 4'b0011 << addr[1:0];
                                bus_wdata_d = {2{wdata[15:0]}};
                            end
                            default: begin
                                bus_wstrb_d = 4'b1111;
                                bus_wdata_d = wdata;
                            end
                        endcase
                        if (!we) bus_wstrb_d = 4'b0000;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                stall = 1'b1;
                // A ready in the would-be timeout cycle wins over the timeout.
                if (bus_ready) begin
                    if (!we_q) rdata_d = rd_ext;
                    state_d = DONE;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        fault_d = 2'b10;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            size_q      <= SZ_BYTE;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            rdata_q     <= '0;
            fault_q     <= 2'b00;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wstrb_q <= '0;
            bus_wdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wstrb_q <= bus_wstrb_d;
            bus_wdata_q <= bus_wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rdata     = rdata_q;
    assign fault     = fault_q;
    assign done      = (state_q == DONE);
    assign bus_valid = (state_q == ACCESS);
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wstrb = bus_wstrb_q;
    assign bus_wdata = bus_wdata_q;

endmodule
